ufo_client_tx: RTL
==================

Name: ufo_client_tx

Overview:
- Client-to-exchange UFO transmitter, the counterpart of the exchange-to-client UFO receiver/parser.
- Takes one command per packet and builds the UFO frame onto an Avalon-ST output toward the TCP engine.
- Supported commands: Login Request ('L'), Heartbeat ('R'), Logoff Request ('O'), Unsequenced Data ('U').
- For 'U', the OUCH payload stream is realigned behind the 3-byte UFO header.

Parameters:
- UFO_DATA_WIDTH, 64, output beat width in bits. Only 64 is supported.
- OUCH_DATA_WIDTH, 64, payload input width in bits. Must equal UFO_DATA_WIDTH.
- HEARTBEAT_CYCLES, 125000000, number of idle output cycles before an automatic heartbeat is sent.

Ports:
- clk  in  1  clock
- areset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_type  in  8  ufo_protocol_pkg::client2exchange_types_t
- cmd_session  in  16  requested session, used by 'L' only
- cmd_sequence  in  32  requested sequence number, used by 'L' only
- cmd_payload_len  in  16  payload byte count, used by 'U' only
- ouch_in_data  in  64  payload data; byte 0 is in [63:56]
- ouch_in_startofpacket  in  1  payload start of packet
- ouch_in_endofpacket  in  1  payload end of packet
- ouch_in_empty  in  3  number of empty bytes on the payload EOP beat
- ouch_in_valid  in  1  payload valid
- ouch_in_ready  out  1  payload ready
- ufo_out_data  out  64  frame data; byte 0 is in [63:56]
- ufo_out_startofpacket  out  1  frame start of packet
- ufo_out_endofpacket  out  1  frame end of packet
- ufo_out_empty  out  3  number of empty bytes on the frame EOP beat
- ufo_out_valid  out  1  frame valid
- ufo_out_ready  in  1  frame ready
- err_bad_cmd  out  1  one-cycle pulse on an unsupported command
- err_len_mismatch  out  1  one-cycle pulse on a payload length mismatch

Behaviour:
- Frame format:
  - Bytes 0-1: packet_length, big-endian, equal to 1 + payload bytes.
  - Byte 2: message type.
  - Remaining bytes: payload.
- Reset (areset_n low at a clk edge):
  - All outputs go to 0, state goes to IDLE, the heartbeat counter is cleared.
  - A frame in flight is abandoned with no EOP sent; the downstream consumer is reset together with this block.
- Output handshake:
  - The output is fully registered.
  - Once ufo_out_valid is high, data, sop, eop and empty hold until ufo_out_ready is seen high.
  - Valid never drops before that handshake completes.
- cmd_ready is high only in IDLE while no output beat is pending.
- Latency: a command accepted in cycle N produces its first beat with valid high in cycle N+1, except 'U' with a non-zero length, whose first beat waits for payload.
- State IDLE:
  - Accept a command.
  - 'R' or 'O': go to LAST with a single beat {0x0001, type, 5 zero bytes}, sop=1, eop=1, empty=5.
  - 'L': go to LOGIN_HDR with beat {0x0007, 'L', session[15:0], seq[31:24..]} carrying 8 bytes, sop=1.
  - 'U' with cmd_payload_len=0: send a header-only beat with length 1, empty=5, eop=1.
  - 'U' otherwise: go to U_FIRST.
  - Any other type, including 'T': accept, drop, pulse err_bad_cmd, stay in IDLE.
- State LOGIN_HDR: after the handshake, send the tail beat {seq[7:0], 7 zero bytes}, eop=1, empty=7, then go to LAST.
- State U_FIRST:
  - ouch_in_ready equals "output register free".
  - Each accepted input beat emits {3 residual bytes, in[63:24]} and stores in[23:0] as the new residual.
  - The initial residual is {len[15:0], 'U'}. The first beat has sop=1.
- State U_BODY: the same shifting as U_FIRST, applied to subsequent input beats.
- Input EOP, with n = 8 − ouch_in_empty:
  - n ≤ 5: the beat is final, eop=1, empty=5−n, return to IDLE.
  - n > 5: go to U_FLUSH, which emits the residual n−5 bytes with eop=1, empty=13−n, ouch_in_ready=0.
- Byte count check:
  - Payload bytes are counted in 16 bits.
  - If the count at input EOP differs from cmd_payload_len, pulse err_len_mismatch on the EOP beat.
  - The frame still ends at input EOP.
- ouch_in_startofpacket is ignored.
- A new command never overlaps a frame in progress.
- Heartbeat counter:
  - Increments every cycle in IDLE with no output pending.
  - Clears whenever an output EOP handshake completes.
  - Saturates at HEARTBEAT_CYCLES.

Optional Feature:
- Macro: UFO_TX_AUTO_HEARTBEAT_EN.
- Defined:
  - When the counter equals HEARTBEAT_CYCLES and the block is in IDLE with cmd_valid low, send an internal 'R' frame.
  - If cmd_valid is high in the same cycle, the command wins and the heartbeat remains due.
- Undefined:
  - No counter is built; heartbeats are sent only via cmd_type 'R'.
  - HEARTBEAT_CYCLES is unused.

Decomposition:
- ufo_protocol_pkg:
  - client2exchange_types_t, already present.
  - UFO_HDR_BYTES=3.
  - UFO_LOGIN_PAYLOAD_BYTES=6.
  - typedef ufo_frame_hdr_t (packed: packet_length[15:0], msgtype).
- Sub-module ufo_tx_realign: the 3-byte residual shifter plus EOP/empty arithmetic, with a valid/ready in and out.
- The top level keeps the FSM, the command mux and the heartbeat counter.

Test Plan:
- 'R' command, ready held high → one beat 0x0001_52_0000000000, sop=eop=1, empty=5, valid in cycle N+1.
- 'L' with session=0x1234, seq=0xAABBCCDD → beat 0x0007_4C_1234_AABBCC sop, then 0xDD00000000000000 eop, empty=7.
- 'U' len=13, payload 8+5 bytes (empty=3) → beats {0x000E,'U',p0..p4}, {p5..p12}, no flush beat, final empty=0.
- 'U' len=7, one input beat with empty=1 (n=7) → first beat with 5 bytes, flush beat carrying p5,p6 with eop, empty=6.
- 'U' len=10 with only 8 payload bytes delivered → err_len_mismatch pulses once; frame ends at input EOP; length field stays 0x000B.
- Random ufo_out_ready stalls during a 'U' frame, then areset_n low for 1 cycle mid-frame → data stable while stalled; after reset all outputs 0, next 'O' frame correct; with UFO_TX_AUTO_HEARTBEAT_EN and HEARTBEAT_CYCLES=16, idle → 'R' frame after 16 cycles.

Source files
------------

// File: rtl/ufo_protocol_pkg.sv
// Shared UFO client-to-exchange types, header layout and byte-count helpers.
package ufo_protocol_pkg;

   typedef enum logic [7:0] {
      C2E_LOGIN_REQ  = 8'h4C,
      C2E_LOGOFF_REQ = 8'h4F,
      C2E_HEARTBEAT  = 8'h52,
      C2E_UNSEQ_DATA = 8'h55
   } client2exchange_types_t;

   localparam int UFO_HDR_BYTES           = 3;
   localparam int UFO_LOGIN_PAYLOAD_BYTES = 6;

   typedef struct packed {
      logic [15:0] packet_length;
      logic [7:0]  msgtype;
   } ufo_frame_hdr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOGIN_HDR,
      ST_U_FIRST,
      ST_U_BODY,
      ST_U_FLUSH,
      ST_LAST
   } tx_state_t;

   // Valid bytes carried by one 8-byte beat.
   function automatic logic [3:0] beat_bytes(input logic eop, input logic [2:0] empty);
      return eop ? (4'd8 - {1'b0, empty}) : 4'd8;
   endfunction

endpackage

// File: rtl/ufo_client_tx_if.sv
// Command, OUCH payload and UFO frame handshakes of ufo_client_tx.
interface ufo_client_tx_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_type;
   logic [15:0] cmd_session;
   logic [31:0] cmd_sequence;
   logic [15:0] cmd_payload_len;

   logic [63:0] ouch_in_data;
   logic        ouch_in_startofpacket;
   logic        ouch_in_endofpacket;
   logic [2:0]  ouch_in_empty;
   logic        ouch_in_valid;
   logic        ouch_in_ready;

   logic [63:0] ufo_out_data;
   logic        ufo_out_startofpacket;
   logic        ufo_out_endofpacket;
   logic [2:0]  ufo_out_empty;
   logic        ufo_out_valid;
   logic        ufo_out_ready;

   logic        err_bad_cmd;
   logic        err_len_mismatch;

   modport master (
      output cmd_valid, cmd_type, cmd_session, cmd_sequence, cmd_payload_len,
      output ouch_in_data, ouch_in_startofpacket, ouch_in_endofpacket, ouch_in_empty, ouch_in_valid,
      output ufo_out_ready,
      input  cmd_ready, ouch_in_ready,
      input  ufo_out_data, ufo_out_startofpacket, ufo_out_endofpacket, ufo_out_empty, ufo_out_valid,
      input  err_bad_cmd, err_len_mismatch
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_session, cmd_sequence, cmd_payload_len,
      input  ouch_in_data, ouch_in_startofpacket, ouch_in_endofpacket, ouch_in_empty, ouch_in_valid,
      input  ufo_out_ready,
      output cmd_ready, ouch_in_ready,
      output ufo_out_data, ufo_out_startofpacket, ufo_out_endofpacket, ufo_out_empty, ufo_out_valid,
      output err_bad_cmd, err_len_mismatch
   );

endinterface

// File: rtl/ufo_tx_realign.sv
// Shifts the OUCH payload behind the 3-byte UFO header using a carried residual;
// an input EOP with more than 5 bytes leaves a pending flush beat.
module ufo_tx_realign
   import ufo_protocol_pkg::*;
(
   input  logic                         clk,
   input  logic                         areset_n,
   input  logic                         init,
   input  logic [UFO_HDR_BYTES*8-1:0]   init_res,
   input  logic                         en,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [63:0]                  in_data,
   input  logic                         in_eop,
   input  logic [2:0]                   in_empty,
   output logic [3:0]                   in_bytes,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [63:0]                  out_data,
   output logic                         out_eop,
   output logic [2:0]                   out_empty
);

   localparam int RES_W = UFO_HDR_BYTES * 8;

   logic [RES_W-1:0] res_q, res_d;
   logic             flush_q, flush_d;
   logic [2:0]       flush_empty_q, flush_empty_d;
   logic             in_fire;

   always_comb begin
      in_bytes = beat_bytes(in_eop, in_empty);
      in_ready = en && !flush_q && out_ready;
      in_fire  = in_valid && in_ready;

      if (flush_q) begin
         out_valid = 1'b1;
         out_data  = {res_q, {(64-RES_W){1'b0}}};
         out_eop   = 1'b1;
         out_empty = flush_empty_q;
      end else begin
         out_valid = en && in_valid;
         out_data  = {res_q, in_data[63:RES_W]};
         out_eop   = in_eop && (in_bytes <= 4'd5);
         out_empty = out_eop ? 3'(4'd5 - in_bytes) : 3'd0;
      end

      res_d         = res_q;
      flush_d       = flush_q;
      flush_empty_d = flush_empty_q;
      if (init) begin
         res_d   = init_res;
         flush_d = 1'b0;
      end else if (in_fire) begin
         res_d = in_data[RES_W-1:0];
         // 6..8 bytes on the EOP beat leave 1..3 residual bytes for a flush beat
         if (in_eop && (in_bytes > 4'd5)) begin
            flush_d       = 1'b1;
            flush_empty_d = 3'(4'd13 - in_bytes);
         end
      end else if (flush_q && out_ready) begin
         flush_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!areset_n) begin
         res_q         <= '0;
         flush_q       <= 1'b0;
         flush_empty_q <= 3'd0;
      end else begin
         res_q         <= res_d;
         flush_q       <= flush_d;
         flush_empty_q <= flush_empty_d;
      end
   end

endmodule

// File: rtl/ufo_client_tx.sv
// UFO client-to-exchange transmitter: command FSM, frame builder and heartbeat timer.
// Optional automatic heartbeat is built when UFO_TX_AUTO_HEARTBEAT_EN is defined.
//
// state        | meaning
// IDLE         | waiting for a command (or a due heartbeat)
// LOGIN_HDR    | login first beat pending, tail beat next
// U_FIRST      | unsequenced data, waiting for first payload beat
// U_BODY       | unsequenced data, subsequent payload beats
// U_FLUSH      | emit residual bytes after an input EOP of 6..8 bytes
// LAST         | final beat loaded, waiting for its handshake
module ufo_client_tx
   import ufo_protocol_pkg::*;
#(
   parameter int UFO_DATA_WIDTH   = 64,
   parameter int OUCH_DATA_WIDTH  = 64,
   parameter int HEARTBEAT_CYCLES = 125000000
) (
   input  logic            clk,
   input  logic            areset_n,
   ufo_client_tx_if.slave  bus
);

   if (UFO_DATA_WIDTH != 64 || OUCH_DATA_WIDTH != UFO_DATA_WIDTH) begin : g_width_check
      $error("ufo_client_tx supports only 64-bit data paths");
   end

   tx_state_t      state_q, state_d;
   logic [63:0]    data_q, data_d;
   logic           sop_q, sop_d;
   logic           eop_q, eop_d;
   logic [2:0]     empty_q, empty_d;
   logic           valid_q, valid_d;
   logic           err_bad_q, err_bad_d;
   logic           err_len_q, err_len_d;
   logic           live_q, live_d;
   logic [15:0]    len_q, len_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [7:0]     seq_lo_q, seq_lo_d;

   logic           free;
   logic           cmd_fire;
   logic           ouch_fire;
   logic           hb_due;
   logic           ra_init;
   logic           ra_en;
   logic           ra_out_valid;
   logic           ra_out_ready;
   logic [63:0]    ra_out_data;
   logic           ra_out_eop;
   logic [2:0]     ra_out_empty;
   logic [3:0]     ra_in_bytes;
   logic [15:0]    cnt_next;
   ufo_frame_hdr_t u_hdr;
   ufo_frame_hdr_t l_hdr;
   logic           unused_in;

   assign free      = !valid_q || bus.ufo_out_ready;
   assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
   assign ouch_fire = bus.ouch_in_valid && bus.ouch_in_ready;
   assign unused_in = bus.ouch_in_startofpacket;

   assign ra_en        = (state_q == ST_U_FIRST) || (state_q == ST_U_BODY);
   assign ra_out_ready = free && (ra_en || state_q == ST_U_FLUSH);
   assign cnt_next     = cnt_q + {12'd0, ra_in_bytes};

   assign u_hdr.packet_length = bus.cmd_payload_len + 16'd1;
   assign u_hdr.msgtype       = C2E_UNSEQ_DATA;
   assign l_hdr.packet_length = 16'(1 + UFO_LOGIN_PAYLOAD_BYTES);
   assign l_hdr.msgtype       = C2E_LOGIN_REQ;

   ufo_tx_realign u_realign (
      .clk       (clk),
      .areset_n  (areset_n),
      .init      (ra_init),
      .init_res  (u_hdr),
      .en        (ra_en),
      .in_valid  (bus.ouch_in_valid),
      .in_ready  (bus.ouch_in_ready),
      .in_data   (bus.ouch_in_data),
      .in_eop    (bus.ouch_in_endofpacket),
      .in_empty  (bus.ouch_in_empty),
      .in_bytes  (ra_in_bytes),
      .out_valid (ra_out_valid),
      .out_ready (ra_out_ready),
      .out_data  (ra_out_data),
      .out_eop   (ra_out_eop),
      .out_empty (ra_out_empty)
   );

`ifdef UFO_TX_AUTO_HEARTBEAT_EN
   localparam logic [31:0] HB_LIMIT = 32'(HEARTBEAT_CYCLES);
   logic [31:0] hb_cnt_q, hb_cnt_d;

   always_comb begin
      hb_cnt_d = hb_cnt_q;
      if (valid_q && eop_q && bus.ufo_out_ready)
         hb_cnt_d = '0;
      else if (state_q == ST_IDLE && !valid_q && hb_cnt_q != HB_LIMIT)
         hb_cnt_d = hb_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!areset_n) hb_cnt_q <= '0;
      else           hb_cnt_q <= hb_cnt_d;
   end

   // A pending command always wins; the heartbeat stays due until sent.
   assign hb_due = live_q && state_q == ST_IDLE && !valid_q && !bus.cmd_valid &&
                   hb_cnt_q == HB_LIMIT;
`else
   logic unused_hb;
   assign unused_hb = (HEARTBEAT_CYCLES != 0);
   assign hb_due    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      empty_d   = empty_q;
      valid_d   = valid_q && !bus.ufo_out_ready;
      err_bad_d = 1'b0;
      err_len_d = 1'b0;
      live_d    = 1'b1;
      len_d     = len_q;
      cnt_d     = cnt_q;
      seq_lo_d  = seq_lo_q;
      ra_init   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               len_d    = bus.cmd_payload_len;
               cnt_d    = 16'd0;
               seq_lo_d = bus.cmd_sequence[7:0];
               case (bus.cmd_type)
                  C2E_HEARTBEAT, C2E_LOGOFF_REQ: begin
                     data_d  = {16'h0001, bus.cmd_type, 40'h0};
                     sop_d   = 1'b1;
                     eop_d   = 1'b1;
                     empty_d = 3'd5;
                     valid_d = 1'b1;
                     state_d = ST_LAST;
                  end
                  C2E_LOGIN_REQ: begin
                     data_d  = {l_hdr, bus.cmd_session, bus.cmd_sequence[31:8]};
                     sop_d   = 1'b1;
                     eop_d   = 1'b0;
                     empty_d = 3'd0;
                     valid_d = 1'b1;
                     state_d = ST_LOGIN_HDR;
                  end
                  C2E_UNSEQ_DATA: begin
                     if (bus.cmd_payload_len == 16'd0) begin
                        data_d  = {u_hdr, 40'h0};
                        sop_d   = 1'b1;
                        eop_d   = 1'b1;
                        empty_d = 3'd5;
                        valid_d = 1'b1;
                        state_d = ST_LAST;
                     end else begin
                        ra_init = 1'b1;
                        state_d = ST_U_FIRST;
                     end
                  end
                  default: err_bad_d = 1'b1;
               endcase
            end else if (hb_due) begin
               data_d  = {16'h0001, C2E_HEARTBEAT, 40'h0};
               sop_d   = 1'b1;
               eop_d   = 1'b1;
               empty_d = 3'd5;
               valid_d = 1'b1;
               state_d = ST_LAST;
            end
         end
         ST_LOGIN_HDR: begin
            if (free) begin
               data_d  = {seq_lo_q, 56'h0};
               sop_d   = 1'b0;
               eop_d   = 1'b1;
               empty_d = 3'd7;
               valid_d = 1'b1;
               state_d = ST_LAST;
            end
         end
         ST_U_FIRST, ST_U_BODY: begin
            if (ouch_fire) begin
               data_d  = ra_out_data;
               sop_d   = (state_q == ST_U_FIRST);
               eop_d   = ra_out_eop;
               empty_d = ra_out_empty;
               valid_d = 1'b1;
               cnt_d   = cnt_next;
               state_d = ST_U_BODY;
               if (bus.ouch_in_endofpacket) begin
                  err_len_d = (cnt_next != len_q);
                  state_d   = ra_out_eop ? ST_IDLE : ST_U_FLUSH;
               end
            end
         end
         ST_U_FLUSH: begin
            if (free && ra_out_valid) begin
               data_d  = ra_out_data;
               sop_d   = 1'b0;
               eop_d   = ra_out_eop;
               empty_d = ra_out_empty;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_LAST: begin
            if (free) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!areset_n) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         empty_q   <= 3'd0;
         valid_q   <= 1'b0;
         err_bad_q <= 1'b0;
         err_len_q <= 1'b0;
         live_q    <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         seq_lo_q  <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         empty_q   <= empty_d;
         valid_q   <= valid_d;
         err_bad_q <= err_bad_d;
         err_len_q <= err_len_d;
         live_q    <= live_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         seq_lo_q  <= seq_lo_d;
      end
   end

   // live_q keeps cmd_ready low in the cycle right after reset.
   assign bus.cmd_ready             = live_q && state_q == ST_IDLE && !valid_q;
   assign bus.ufo_out_data          = data_q;
   assign bus.ufo_out_startofpacket = sop_q;
   assign bus.ufo_out_endofpacket   = eop_q;
   assign bus.ufo_out_empty         = empty_q;
   assign bus.ufo_out_valid         = valid_q;
   assign bus.err_bad_cmd           = err_bad_q;
   assign bus.err_len_mismatch      = err_len_q;

endmodule
